// File: rtl/window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : window_gen
//  Purpose  : Sliding WIN x WIN pixel window generator over a raster stream.
//             WIN-1 line buffers feed a shift-register window anchored at the
//             bottom-right (newest pixel at tap (WIN-1,WIN-1)).
//  Config   : `define WINDOW_EDGE_ZERO_EN to emit windows from column 0 with
//             the taps left of the image edge forced to zero.
//  Revision : 1.0  initial release
// ============================================================================
module window_gen #(
  parameter int DATA_W = 8,
  parameter int WIN    = 7,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data_enable,
  input  logic                          sof,
  input  logic [DATA_W-1:0]             data_in,
  output logic                          win_valid,
  output logic [WIN*WIN*DATA_W-1:0]     win_data,
  output logic [$clog2(IMG_W)-1:0]      center_col,
  output logic [$clog2(IMG_H)-1:0]      center_row,
  output logic                          frame_done
);

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int WIN_BW = WIN * WIN * DATA_W;

  localparam logic [COL_W-1:0] c_COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] c_ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] c_ROW_FIRST = ROW_W'(WIN - 1);
  localparam logic [COL_W-1:0] c_HALF_COL  = COL_W'(WIN / 2);
  localparam logic [ROW_W-1:0] c_HALF_ROW  = ROW_W'(WIN / 2);

  // Position of the next expected pixel
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;

  // Line buffers: index 0 holds the previous line, index WIN-2 the oldest
  logic [DATA_W-1:0] r_lb [0:WIN-2][0:IMG_W-1];

  // Registered window and output qualifiers
  logic [WIN_BW-1:0] r_win;
  logic              r_valid;
  logic              r_frame_done;
  logic [COL_W-1:0]  r_center_col;
  logic [ROW_W-1:0]  r_center_row;

  // Effective coordinates of the pixel on the input this cycle
  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;
  logic [DATA_W-1:0] w_col_vec [0:WIN-1];
  logic [DATA_W-1:0] w_tap;
  logic [WIN_BW-1:0] w_win_next;
  logic              w_valid_next;
  logic              w_last_pixel;

  // A start-of-frame pixel is always (0,0), whatever the counters say
  assign w_col = sof ? '0 : r_col;
  assign w_row = sof ? '0 : r_row;

  assign w_last_pixel = (w_row == c_ROW_LAST) && (w_col == c_COL_LAST);

`ifdef WINDOW_EDGE_ZERO_EN
  assign w_valid_next = data_enable && (w_row >= c_ROW_FIRST);
`else
  assign w_valid_next = data_enable && (w_row >= c_ROW_FIRST) &&
                        (w_col >= COL_W'(WIN - 1));
`endif

  // New right-hand column: line buffers (oldest on top) plus the incoming pixel
  always_comb begin
    for (int r = 0; r < WIN; r++) begin
      w_col_vec[r] = '0;
    end
    for (int r = 0; r < WIN - 1; r++) begin
      w_col_vec[r] = r_lb[WIN-2-r][w_col];
    end
    w_col_vec[WIN-1] = data_in;
  end

  // Next window: shift every row one tap left and append the new column
  always_comb begin
    w_win_next = '0;
    w_tap      = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        if (c == WIN - 1) begin
          w_tap = w_col_vec[r];
        end else begin
          w_tap = r_win[(r*WIN+c+1)*DATA_W +: DATA_W];
        end
`ifdef WINDOW_EDGE_ZERO_EN
        // Taps left of column 0 would otherwise carry the previous line's tail
        if ((int'(w_col) + c) < (WIN - 1)) begin
          w_tap = '0;
        end
`endif
        w_win_next[(r*WIN+c)*DATA_W +: DATA_W] = w_tap;
      end
    end
  end

  // Raster position counters, restarted by sof and wrapping at frame end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (data_enable) begin
      if (w_col == c_COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row == c_ROW_LAST) ? '0 : w_row + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
    end
  end

  // Line buffers cascade one line per stage; contents are never reset
  always_ff @(posedge clk) begin
    if (data_enable) begin
      r_lb[0][w_col] <= data_in;
      for (int k = 1; k < WIN - 1; k++) begin
        r_lb[k][w_col] <= r_lb[k-1][w_col];
      end
    end
  end

  // Registered window, centre coordinates, valid and end-of-frame pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win        <= '0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      r_center_col <= '0;
      r_center_row <= '0;
    end else begin
      r_valid      <= w_valid_next;
      r_frame_done <= data_enable && w_last_pixel;
      if (data_enable) begin
        r_win        <= w_win_next;
        r_center_col <= w_col - c_HALF_COL;
        r_center_row <= w_row - c_HALF_ROW;
      end
    end
  end

  assign win_valid  = r_valid;
  assign win_data   = r_win;
  assign center_col = r_center_col;
  assign center_row = r_center_row;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window_gen
//  Purpose  : Directed self-checking bench for window_gen (3x3 on 8x8 frames,
//             pixel value = row*8+col).
//  Revision : 1.0  initial release
// ============================================================================
module tb_window_gen;

`ifdef WINDOW_EDGE_ZERO_EN
  localparam bit EDGE      = 1'b1;
  localparam int EXP_WINS  = 48;
`else
  localparam bit EDGE      = 1'b0;
  localparam int EXP_WINS  = 36;
`endif

  logic        clk;
  logic        reset;
  logic        data_enable;
  logic        sof;
  logic [7:0]  data_in;
  logic        win_valid;
  logic [71:0] win_data;
  logic [2:0]  center_col;
  logic [2:0]  center_row;
  logic        frame_done;

  int n_checks;
  int n_errors;
  int n_wins;
  int m_row;
  int m_col;
  bit prev_valid;
  logic [71:0] prev_win;

  window_gen #(
    .DATA_W (8),
    .WIN    (3),
    .IMG_W  (8),
    .IMG_H  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_enable (data_enable),
    .sof         (sof),
    .data_in     (data_in),
    .win_valid   (win_valid),
    .win_data    (win_data),
    .center_col  (center_col),
    .center_row  (center_row),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected window for the pixel at (row,col): tap(r,c) = pixel(row-2+r, col-2+c)
  function automatic logic [71:0] model(input int row, input int col);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if ((col - 2 + c) >= 0 && (row - 2 + r) >= 0) begin
          w[(r*3+c)*8 +: 8] = 8'((row - 2 + r) * 8 + (col - 2 + c));
        end
      end
    end
    return w;
  endfunction

  // One accepted pixel at the bench's expected raster position
  task automatic push(input bit s);
    bit exp_valid;
    if (s) begin
      m_row = 0;
      m_col = 0;
    end
    @(negedge clk);
    data_enable = 1'b1;
    sof         = s;
    data_in     = 8'(m_row * 8 + m_col);
    @(posedge clk);
    #1;
    exp_valid = (m_row >= 2) && (EDGE || (m_col >= 2));
    check("win_valid", {127'd0, win_valid}, {127'd0, exp_valid});
    check("frame_done", {127'd0, frame_done}, {127'd0, (m_row == 7 && m_col == 7)});
    if (exp_valid) begin
      check("win_data", {56'd0, win_data}, {56'd0, model(m_row, m_col)});
      check("center_col", {125'd0, center_col}, 128'((m_col - 1) & 7));
      check("center_row", {125'd0, center_row}, 128'((m_row - 1) & 7));
    end
    if (win_valid) n_wins++;
    prev_valid = exp_valid;
    prev_win   = model(m_row, m_col);
    if (m_col == 7) begin
      m_col = 0;
      m_row = (m_row == 7) ? 0 : m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
  endtask

  // One cycle with no pixel: window must drop valid and hold its data
  task automatic idle();
    @(negedge clk);
    data_enable = 1'b0;
    sof         = 1'b0;
    @(posedge clk);
    #1;
    check("idle_valid", {127'd0, win_valid}, 128'd0);
    check("idle_frame_done", {127'd0, frame_done}, 128'd0);
    if (prev_valid) begin
      check("idle_hold", {56'd0, win_data}, {56'd0, prev_win});
    end
  endtask

  task automatic run(input int n, input bit first_sof, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        for (int g = 0; g < int'($urandom_range(1, 2)); g++) idle();
      end
      push(first_sof && (i == 0));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {127'd0, win_valid}, 128'd0);
    check({tag, "_data"}, {56'd0, win_data}, 128'd0);
    check({tag, "_ccol"}, {125'd0, center_col}, 128'd0);
    check({tag, "_crow"}, {125'd0, center_row}, 128'd0);
    check({tag, "_fdone"}, {127'd0, frame_done}, 128'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    n_wins      = 0;
    m_row       = 0;
    m_col       = 0;
    prev_valid  = 1'b0;
    prev_win    = '0;
    reset       = 1'b1;
    data_enable = 1'b0;
    sof         = 1'b0;
    data_in     = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Frame A: no sof, first pixel after release must be (0,0)
    n_wins = 0;
`ifdef WINDOW_EDGE_ZERO_EN
    run(16, 1'b0, 1'b0);
    push(1'b0);                                   // pixel (2,0)
    check("e20_t00", {120'd0, win_data[7:0]},   128'd0);
    check("e20_t01", {120'd0, win_data[15:8]},  128'd0);
    check("e20_t11", {120'd0, win_data[39:32]}, 128'd0);
    check("e20_t21", {120'd0, win_data[63:56]}, 128'd0);
    check("e20_t22", {120'd0, win_data[71:64]}, 128'd16);
    check("e20_ccol", {125'd0, center_col}, 128'd7);
    push(1'b0);                                   // pixel (2,1)
    check("e21_t10", {120'd0, win_data[31:24]}, 128'd0);
    check("e21_t20", {120'd0, win_data[55:48]}, 128'd0);
    check("e21_t11", {120'd0, win_data[39:32]}, 128'd8);
    check("e21_t21", {120'd0, win_data[63:56]}, 128'd16);
    check("e21_t22", {120'd0, win_data[71:64]}, 128'd17);
    run(46, 1'b0, 1'b0);
`else
    run(18, 1'b0, 1'b0);
    push(1'b0);                                   // pixel (2,2)
    check("p22_valid", {127'd0, win_valid}, 128'd1);
    check("p22_t00", {120'd0, win_data[7:0]},   128'd0);
    check("p22_t11", {120'd0, win_data[39:32]}, 128'd9);
    check("p22_t22", {120'd0, win_data[71:64]}, 128'd18);
    check("p22_ccol", {125'd0, center_col}, 128'd1);
    check("p22_crow", {125'd0, center_row}, 128'd1);
    run(45, 1'b0, 1'b0);
`endif
    check("wins_A", 128'(n_wins), 128'(EXP_WINS));

    // Back-to-back frames: B with sof, C without, no gap in between
    n_wins = 0;
    run(64, 1'b1, 1'b0);
    check("wins_B", 128'(n_wins), 128'(EXP_WINS));
    n_wins = 0;
    run(64, 1'b0, 1'b0);
    check("wins_C", 128'(n_wins), 128'(EXP_WINS));
    idle();

    // Random idle gaps: same windows, same count
    n_wins = 0;
    run(64, 1'b1, 1'b1);
    idle();
    check("wins_gap", 128'(n_wins), 128'(EXP_WINS));

    // sof at pixel (4,3) of a running frame restarts the raster
    run(35, 1'b0, 1'b0);
    n_wins = 0;
    run(64, 1'b1, 1'b0);
    idle();
    check("wins_sof", 128'(n_wins), 128'(EXP_WINS));

    // Reset while at pixel (5,5): outputs clear at once, raster restarts
    run(45, 1'b0, 1'b0);
    @(negedge clk);
    data_enable = 1'b0;
    reset       = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    reset      = 1'b0;
    m_row      = 0;
    m_col      = 0;
    prev_valid = 1'b0;
    n_wins     = 0;
    run(64, 1'b0, 1'b0);
    idle();
    check("wins_rst", 128'(n_wins), 128'(EXP_WINS));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/window_gen.md
WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits.
REQ-002 Parameter WIN, default 7, window side length; odd, 3..9.
REQ-003 Parameter IMG_W, default 64, pixels per line; must be >= WIN.
REQ-004 Parameter IMG_H, default 64, lines per frame; must be >= WIN.
REQ-005 Port clk  input  1  sole clock; all logic rising-edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port data_enable  input  1  pixel accepted on this cycle.
REQ-008 Port sof  input  1  start of frame; qualified by data_enable.
REQ-009 Port data_in  input  DATA_W  pixel value.
REQ-010 Port win_valid  output  1  win_data and center coordinates valid.
REQ-011 Port win_data  output  WIN*WIN*DATA_W  window; tap (r,c) at bits [(r*WIN+c)*DATA_W +: DATA_W]; r=0 oldest row, c=0 leftmost column.
REQ-012 Port center_col  output  clog2(IMG_W)  column of the window centre pixel.
REQ-013 Port center_row  output  clog2(IMG_H)  row of the window centre pixel.
REQ-014 Port frame_done  output  1  one-cycle pulse after the last pixel of a frame.

Function
REQ-015 The block SHALL keep col/row counters of the next expected pixel; col wraps IMG_W-1->0 and increments row; after (IMG_H-1, IMG_W-1) both SHALL return to 0.
REQ-016 Accepting a pixel with sof=1 SHALL treat it as pixel (0,0) regardless of counter state; counters then continue from (0,1).
REQ-017 The block SHALL hold WIN-1 line buffers of IMG_W x DATA_W plus a WIN x WIN shift-register window; all state advances only on data_enable=1.
REQ-018 The window SHALL be anchored bottom-right: tap (WIN-1,WIN-1) = pixel just accepted; tap (r,c) = pixel at (row-(WIN-1-r), col-(WIN-1-c)).
REQ-019 win_valid, win_data, center_col and center_row SHALL be registered and update exactly 1 cycle after the accepted pixel; latency 1 cycle.
REQ-020 center_row = row-WIN/2 and center_col = col-WIN/2 (integer division) of the accepted pixel.
REQ-021 win_valid SHALL be 0 in any cycle following a cycle with data_enable=0; win_data SHALL hold its last value.
REQ-022 win_valid SHALL be 0 for any pixel with row < WIN-1.
REQ-023 frame_done SHALL pulse for one cycle, 1 cycle after pixel (IMG_H-1, IMG_W-1) is accepted; simultaneous sof on the next pixel is legal and needs no gap.
REQ-024 No back-pressure: the block SHALL accept a pixel on every cycle data_enable=1, back-to-back indefinitely.

Reset
REQ-025 reset SHALL asynchronously clear counters, win_valid, frame_done, center_col, center_row and win_data to 0.
REQ-026 Line-buffer contents need not be cleared; stale data SHALL never appear in a valid window since REQ-022 gates output until WIN-1 fresh rows exist.
REQ-027 Reset mid-frame SHALL restart at pixel (0,0) on the first accepted pixel after release.

Configuration
REQ-028 Macro WINDOW_EDGE_ZERO_EN SHALL select left-edge handling.
REQ-029 Without WINDOW_EDGE_ZERO_EN: win_valid=1 only for pixels with row >= WIN-1 and col >= WIN-1.
REQ-030 With WINDOW_EDGE_ZERO_EN: win_valid=1 for every pixel with row >= WIN-1; taps with c < WIN-1-col SHALL be forced to 0 (no wrap from previous line); center_col/center_row SHALL still follow REQ-020 (modulo their width).

Verification
REQ-031 Bench SHALL use DATA_W=8, WIN=3, IMG_W=8, IMG_H=8, pixel value row*8+col, and cover:
- Reset asserted -> all outputs 0; first pixel after release treated as (0,0).
- Full frame, macro off -> first win_valid 1 cycle after pixel (2,2); tap(0,0)=0, tap(1,1)=9, tap(2,2)=18, centre (1,1); 36 valid windows total.
- Full frame, macro on -> first win_valid after pixel (2,0) with taps c=0,1 zero, tap(2,2)=16; after (2,1) only c=0 taps zero; 48 valid windows.
- Random data_enable gaps -> identical valid-window sequence as gap-free run; win_valid 0 after every idle cycle.
- sof at pixel (4,3) mid-frame -> counters restart; no win_valid until row 2 of new frame; frame_done only after 64 pixels from sof.
- Back-to-back frames -> frame_done single pulse after pixel 63; next pixel (with or without sof) is (0,0); reset at pixel (5,5) -> no valid output until row 2 after restart.
